// File: rtl/axi_slave_sram.sv
// AXI4 slave backed by a 2^AW x 32-bit SRAM, one burst in flight.
// Ports: clock/reset, io_slave_{aw,w,b,ar,r}* AXI4 channels.
module axi_slave_sram #(
  parameter logic [31:0] BASE = 32'h8000_0000,
  parameter int          AW   = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_slave_awvalid,
  output logic        io_slave_awready,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  input  logic        io_slave_wvalid,
  output logic        io_slave_wready,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  output logic        io_slave_bvalid,
  input  logic        io_slave_bready,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  input  logic        io_slave_arvalid,
  output logic        io_slave_arready,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  output logic        io_slave_rvalid,
  input  logic        io_slave_rready,
  output logic [31:0] io_slave_rdata,
  output logic [1:0]  io_slave_rresp,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD    = 2'd1;
  localparam logic [1:0] WR    = 2'd2;
  localparam logic [1:0] WRESP = 2'd3;

  logic [1:0]  state;
  logic        prio_w;
  logic [31:0] addr;
  logic [7:0]  len;
  logic [7:0]  beat;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic [3:0]  id;
  logic        werr;
  logic        over;

  logic [31:0] mem [0:(1<<AW)-1];

  // Region match, legal burst type (FIXED/INCR) and size up to a word.
  function automatic logic in_rng(
    input logic [31:0] a,
    input logic [1:0]  b,
    input logic [2:0]  s
  );
    logic [31:0] d;
    d = (a ^ BASE) >> (AW + 2);
    return (d == 32'd0) && !b[1] && (s <= 3'd2);
  endfunction

  function automatic logic [31:0] step(
    input logic [31:0] a,
    input logic [1:0]  b,
    input logic [2:0]  s
  );
    return (b == 2'b01) ? a + (32'd1 << s) : a;
  endfunction

  logic        ar_hs;
  logic        aw_hs;
  logic        r_hs;
  logic        w_hs;
  logic        b_hs;
  logic        w_bad;
  logic        w_ok;
  logic        ar_ok;
  logic        nx_ok;
  logic [31:0] nxt;

  // Conflicting requests go to whichever type was not granted last.
  assign io_slave_arready = (state == IDLE) &&
                            !(io_slave_awvalid && prio_w);
  assign io_slave_awready = (state == IDLE) &&
                            !(io_slave_arvalid && !prio_w);

  assign ar_hs = io_slave_arvalid && io_slave_arready;
  assign aw_hs = io_slave_awvalid && io_slave_awready;
  assign r_hs  = io_slave_rvalid && io_slave_rready;
  assign w_hs  = io_slave_wvalid && io_slave_wready;
  assign b_hs  = io_slave_bvalid && io_slave_bready;

  assign nxt   = step(addr, burst, size);
  assign ar_ok = in_rng(io_slave_araddr, io_slave_arburst,
                        io_slave_arsize);
  assign nx_ok = in_rng(nxt, burst, size);
  assign w_bad = !in_rng(addr, burst, size);
  assign w_ok  = w_hs && !over && !w_bad;

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (w_ok && io_slave_wstrb[b])
        mem[addr[AW+1:2]][8*b +: 8] <= io_slave_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      prio_w          <= 1'b0;
      addr            <= '0;
      len             <= '0;
      beat            <= '0;
      size            <= '0;
      burst           <= '0;
      id              <= '0;
      werr            <= 1'b0;
      over            <= 1'b0;
      io_slave_rvalid <= 1'b0;
      io_slave_rdata  <= '0;
      io_slave_rresp  <= '0;
      io_slave_rlast  <= 1'b0;
      io_slave_rid    <= '0;
      io_slave_wready <= 1'b0;
      io_slave_bvalid <= 1'b0;
      io_slave_bresp  <= '0;
      io_slave_bid    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ar_hs) begin
            addr            <= io_slave_araddr;
            len             <= io_slave_arlen;
            size            <= io_slave_arsize;
            burst           <= io_slave_arburst;
            beat            <= '0;
            prio_w          <= 1'b1;
            state           <= RD;
            io_slave_rvalid <= 1'b1;
            io_slave_rid    <= io_slave_arid;
            io_slave_rlast  <= (io_slave_arlen == 8'd0);
            io_slave_rdata  <= ar_ok ?
              mem[io_slave_araddr[AW+1:2]] : 32'd0;
            io_slave_rresp  <= ar_ok ? 2'b00 : 2'b10;
          end else if (aw_hs) begin
            addr            <= io_slave_awaddr;
            len             <= io_slave_awlen;
            size            <= io_slave_awsize;
            burst           <= io_slave_awburst;
            id              <= io_slave_awid;
            beat            <= '0;
            werr            <= 1'b0;
            over            <= 1'b0;
            prio_w          <= 1'b0;
            state           <= WR;
            io_slave_wready <= 1'b1;
          end
        end
        RD: begin
          if (r_hs) begin
            if (io_slave_rlast) begin
              state           <= IDLE;
              io_slave_rvalid <= 1'b0;
              io_slave_rlast  <= 1'b0;
            end else begin
              addr           <= nxt;
              beat           <= beat + 8'd1;
              io_slave_rlast <= (beat + 8'd1 == len);
              io_slave_rdata <= nx_ok ? mem[nxt[AW+1:2]] : 32'd0;
              io_slave_rresp <= nx_ok ? 2'b00 : 2'b10;
            end
          end
        end
        WR: begin
          if (w_hs) begin
            if (io_slave_wlast) begin
              state           <= WRESP;
              io_slave_wready <= 1'b0;
              io_slave_bvalid <= 1'b1;
              io_slave_bid    <= id;
              io_slave_bresp  <= (werr || w_bad || over ||
                                  beat != len) ? 2'b10 : 2'b00;
            end else if (over || beat == len) begin
              // Too many beats: swallow them until wlast.
              over <= 1'b1;
            end else begin
              beat <= beat + 8'd1;
              addr <= nxt;
              werr <= werr || w_bad;
            end
          end
        end
        WRESP: begin
          if (b_hs) begin
            state           <= IDLE;
            io_slave_bvalid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_sram.sv
// Randomized self-checking bench for axi_slave_sram.
// Uses a word-array reference model of the SRAM and AXI rules.
module tb_axi_slave_sram;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = 0;
  logic [3:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic [2:0]  awsize = 0;
  logic [1:0]  awburst = 0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wlast = 0;
  logic        bvalid, bready = 0;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = 0;
  logic [3:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic [2:0]  arsize = 0;
  logic [1:0]  arburst = 0;
  logic        rvalid, rready = 0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  always #5 clock = ~clock;

  axi_slave_sram dut (
    .clock(clock), .reset(reset),
    .io_slave_awvalid(awvalid), .io_slave_awready(awready),
    .io_slave_awaddr(awaddr), .io_slave_awid(awid),
    .io_slave_awlen(awlen), .io_slave_awsize(awsize),
    .io_slave_awburst(awburst),
    .io_slave_wvalid(wvalid), .io_slave_wready(wready),
    .io_slave_wdata(wdata), .io_slave_wstrb(wstrb),
    .io_slave_wlast(wlast),
    .io_slave_bvalid(bvalid), .io_slave_bready(bready),
    .io_slave_bresp(bresp), .io_slave_bid(bid),
    .io_slave_arvalid(arvalid), .io_slave_arready(arready),
    .io_slave_araddr(araddr), .io_slave_arid(arid),
    .io_slave_arlen(arlen), .io_slave_arsize(arsize),
    .io_slave_arburst(arburst),
    .io_slave_rvalid(rvalid), .io_slave_rready(rready),
    .io_slave_rdata(rdata), .io_slave_rresp(rresp),
    .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  int passed = 0;
  int total = 0;

  logic [31:0] model [0:1023];
  logic [31:0] wd [0:511];
  logic [3:0]  ws [0:511];
  logic [31:0] rd_data [0:511];
  logic [1:0]  rd_resp [0:511];
  logic        rd_last [0:511];
  logic [3:0]  rd_id [0:511];
  int          rd_n;
  int          rd_lat;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  function automatic logic ref_ok(input logic [31:0] a,
                                  input logic [1:0] b,
                                  input logic [2:0] s);
    return a[31:12] == 20'h80000 && b < 2'd2 && s <= 3'd2;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a,
                                            input logic [1:0] b,
                                            input logic [2:0] s,
                                            input int i);
    if (b != 2'b01) return a;
    return a + 32'(i) * (32'd1 << s);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a,
                                           input logic [1:0] b,
                                           input logic [2:0] s,
                                           input int i);
    logic [31:0] ba;
    ba = beat_addr(a, b, s, i);
    return ref_ok(ba, b, s) ? model[ba[11:2]] : 32'd0;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu, input int nb,
                          input int bdly);
    bit got;
    int n;
    logic [31:0] ba;
    @(negedge clock);
    awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bu;
    awvalid = 1;
    got = 0; n = 0;
    while (!got && n < 50) begin
      #1 got = awready;
      @(negedge clock);
      n++;
    end
    awvalid = 0;
    total++;
    if (!got) $display("FAIL aw_timeout got %0d want 1", got);
    else passed++;
    for (int i = 0; i < nb; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == nb - 1);
      wvalid = 1;
      got = 0; n = 0;
      while (!got && n < 50) begin
        #1 got = wready;
        @(negedge clock);
        n++;
      end
      total++;
      if (!got) $display("FAIL w_timeout beat %0d got 0 want 1", i);
      else passed++;
    end
    wvalid = 0; wlast = 0;
    repeat (bdly) @(negedge clock);
    bready = 1;
    got = 0; n = 0;
    while (!got && n < 50) begin
      #1 got = bvalid;
      b_resp = bresp; b_id = bid;
      @(negedge clock);
      n++;
    end
    bready = 0;
    total++;
    if (!got) $display("FAIL b_timeout got 0 want 1");
    else passed++;
    for (int i = 0; i < nb; i++) begin
      ba = beat_addr(a, bu, sz, i);
      if (i <= int'(len) && ref_ok(ba, bu, sz))
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) model[ba[11:2]][8*b +: 8] = wd[i][8*b +: 8];
    end
  endtask

  // mode 0: rready held high, 1: toggles 1/0, 2: random
  task automatic do_read(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input int mode);
    bit got, done, stalled;
    int n, cyc;
    logic [39:0] snap;
    @(negedge clock);
    araddr = a; arid = id; arlen = len; arsize = sz; arburst = bu;
    arvalid = 1;
    got = 0; n = 0;
    while (!got && n < 50) begin
      #1 got = arready;
      @(negedge clock);
      n++;
    end
    arvalid = 0;
    total++;
    if (!got) $display("FAIL ar_timeout got 0 want 1");
    else passed++;
    rd_n = 0; rd_lat = 0; cyc = 0; done = 0; stalled = 0; snap = '0;
    while (!done && cyc < 400) begin
      cyc++;
      if (mode == 0) rready = 1;
      else if (mode == 1) rready = cyc[0];
      else rready = 1'($urandom_range(0, 1));
      #1;
      if (rvalid && rd_lat == 0) rd_lat = cyc;
      if (stalled) begin
        total++;
        if ({rvalid, rdata, rresp, rlast, rid} !== snap)
          $display("FAIL r_hold got %h want %h",
                   {rvalid, rdata, rresp, rlast, rid}, snap);
        else passed++;
        stalled = 0;
      end
      if (rvalid && rready) begin
        rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp;
        rd_last[rd_n] = rlast; rd_id[rd_n] = rid;
        rd_n++;
        if (rlast || rd_n >= 300) done = 1;
      end else if (rvalid) begin
        stalled = 1;
        snap = {rvalid, rdata, rresp, rlast, rid};
      end
      @(negedge clock);
    end
    rready = 0;
    total++;
    if (!done) $display("FAIL r_timeout got %0d beats", rd_n);
    else passed++;
    #1;
    total++;
    if (rvalid !== 1'b0)
      $display("FAIL r_after_last got %b want 0", rvalid);
    else passed++;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    total++;
    if ({rvalid, bvalid, wready, rlast, rresp, bresp, rid, bid, rdata}
        !== '0)
      $display("FAIL reset_outs got %h want 0",
               {rvalid, bvalid, wready, rlast, rresp, bresp, rid, bid,
                rdata});
    else passed++;
    total++;
    if ({arready, awready} !== 2'b11)
      $display("FAIL reset_ready got %b want 11", {arready, awready});
    else passed++;
    reset = 0;
  endtask

  task automatic test_arbitration;
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0;
    araddr = 32'h8000_0010; arid = 1; arlen = 0; arsize = 2;
    arburst = 1;
    awaddr = 32'h8000_0030; awid = 2; awlen = 0; awsize = 2;
    awburst = 1;
    arvalid = 1; awvalid = 1;
    #1;
    total++;
    if ({arready, awready} !== 2'b10)
      $display("FAIL arb_first got %b want 10", {arready, awready});
    else passed++;
    @(negedge clock);
    arvalid = 0; awvalid = 0; rready = 1;
    #1;
    total++;
    if (rvalid !== 1'b1) $display("FAIL arb_rvalid got %b want 1", rvalid);
    else passed++;
    @(negedge clock);
    rready = 0;
    arvalid = 1; awvalid = 1; wvalid = 1;
    wdata = 32'hCAFE_0030; wstrb = 4'hF; wlast = 1;
    #1;
    total++;
    if ({arready, awready, wready} !== 3'b010)
      $display("FAIL arb_second got %b want 010",
               {arready, awready, wready});
    else passed++;
    @(negedge clock);
    arvalid = 0; awvalid = 0;
    #1;
    total++;
    if (wready !== 1'b1) $display("FAIL arb_wready got %b want 1", wready);
    else passed++;
    @(negedge clock);
    wvalid = 0; wlast = 0; bready = 1;
    #1;
    total++;
    if ({bvalid, bresp, bid} !== {1'b1, 2'b00, 4'd2})
      $display("FAIL arb_b got %h want %h", {bvalid, bresp, bid},
               {1'b1, 2'b00, 4'd2});
    else passed++;
    @(negedge clock);
    bready = 0;
    model[12] = 32'hCAFE_0030;
  endtask

  task automatic test_single;
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(32'h8000_0010, 3, 0, 2, 1, 1, 2);
    total++;
    if ({b_resp, b_id} !== {2'b00, 4'd3})
      $display("FAIL single_b got %h want %h", {b_resp, b_id},
               {2'b00, 4'd3});
    else passed++;
    do_read(32'h8000_0010, 5, 0, 2, 1, 0);
    total++;
    if (rd_n !== 1 || {rd_data[0], rd_resp[0], rd_id[0], rd_last[0]}
        !== {32'hDEAD_BEEF, 2'b00, 4'd5, 1'b1})
      $display("FAIL single_r got %h want %h",
               {rd_data[0], rd_resp[0], rd_id[0], rd_last[0]},
               {32'hDEAD_BEEF, 2'b00, 4'd5, 1'b1});
    else passed++;
    total++;
    if (rd_lat !== 1) $display("FAIL single_lat got %0d want 1", rd_lat);
    else passed++;
  endtask

  task automatic test_incr_read;
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1); ws[i] = 4'hF;
    end
    do_write(32'h8000_0000, 7, 3, 2, 1, 4, 0);
    total++;
    if (b_resp !== 2'b00) $display("FAIL incr_b got %b want 00", b_resp);
    else passed++;
    do_read(32'h8000_0000, 9, 3, 2, 1, 1);
    total++;
    if (rd_n !== 4) $display("FAIL incr_n got %0d want 4", rd_n);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({rd_data[i], rd_resp[i], rd_last[i]} !==
          {32'(i + 1), 2'b00, i == 3})
        $display("FAIL incr_beat%0d got %h want %h", i,
                 {rd_data[i], rd_resp[i], rd_last[i]},
                 {32'(i + 1), 2'b00, i == 3});
      else passed++;
    end
  endtask

  task automatic test_strobe;
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    do_write(32'h8000_0020, 1, 0, 2, 1, 1, 0);
    wd[0] = 32'h0000_AB00; ws[0] = 4'b0010;
    do_write(32'h8000_0020, 1, 0, 2, 1, 1, 0);
    do_read(32'h8000_0020, 1, 0, 2, 1, 0);
    total++;
    if (rd_data[0] !== 32'h1122_AB44)
      $display("FAIL strobe got %h want 1122ab44", rd_data[0]);
    else passed++;
  endtask

  task automatic test_error;
    logic [31:0] w0;
    w0 = model[0];
    do_read(32'h0000_1000, 2, 1, 2, 1, 0);
    total++;
    if (rd_n !== 2) $display("FAIL err_rn got %0d want 2", rd_n);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({rd_data[i], rd_resp[i], rd_last[i]} !==
          {32'd0, 2'b10, i == 1})
        $display("FAIL err_rbeat%0d got %h want %h", i,
                 {rd_data[i], rd_resp[i], rd_last[i]},
                 {32'd0, 2'b10, i == 1});
      else passed++;
    end
    wd[0] = 32'h5A5A_5A5A; ws[0] = 4'hF;
    do_write(32'h0000_1000, 4, 1, 2, 1, 1, 0);
    total++;
    if ({b_resp, b_id} !== {2'b10, 4'd4})
      $display("FAIL err_b got %h want %h", {b_resp, b_id},
               {2'b10, 4'd4});
    else passed++;
    do_read(32'h8000_0000, 2, 0, 2, 1, 0);
    total++;
    if (rd_data[0] !== w0)
      $display("FAIL err_mem got %h want %h", rd_data[0], w0);
    else passed++;
    wd[0] = 32'hAAAA_0001; wd[1] = 32'hAAAA_0002;
    ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h8000_0040, 6, 1, 2, 1, 2, 0);
    wd[0] = 32'h55; wd[1] = 32'h66;
    do_write(32'h8000_0040, 6, 0, 2, 1, 2, 1);
    total++;
    if (b_resp !== 2'b10) $display("FAIL err_long got %b want 10", b_resp);
    else passed++;
    wd[0] = 32'h77;
    do_write(32'h8000_0040, 6, 1, 2, 1, 1, 0);
    total++;
    if (b_resp !== 2'b10) $display("FAIL err_short got %b want 10", b_resp);
    else passed++;
    do_read(32'h8000_0040, 6, 1, 2, 1, 0);
    total++;
    if ({rd_data[0], rd_data[1]} !== {32'h77, 32'hAAAA_0002})
      $display("FAIL err_len_mem got %h want %h",
               {rd_data[0], rd_data[1]}, {32'h77, 32'hAAAA_0002});
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit got;
    int n;
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom; ws[i] = 4'hF;
    end
    do_write(32'h8000_0100, 2, 3, 2, 1, 4, 0);
    @(negedge clock);
    araddr = 32'h8000_0100; arid = 3; arlen = 3; arsize = 2;
    arburst = 1; arvalid = 1; rready = 1;
    got = 0; n = 0;
    while (!got && n < 50) begin
      #1 got = arready;
      @(negedge clock);
      n++;
    end
    arvalid = 0;
    @(negedge clock);
    #1;
    total++;
    if ({rvalid, rdata} !== {1'b1, model[65]})
      $display("FAIL mid_beat2 got %h want %h", {rvalid, rdata},
               {1'b1, model[65]});
    else passed++;
    reset = 1; rready = 0;
    #1;
    total++;
    if ({rvalid, arready, awready} !== 3'b011)
      $display("FAIL mid_reset got %b want 011",
               {rvalid, arready, awready});
    else passed++;
    @(negedge clock);
    reset = 0;
    do_read(32'h8000_0100, 4, 3, 2, 1, 2);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({rd_data[i], rd_resp[i], rd_id[i]} !==
          {model[64 + i], 2'b00, 4'd4})
        $display("FAIL mid_after%0d got %h want %h", i,
                 {rd_data[i], rd_resp[i], rd_id[i]},
                 {model[64 + i], 2'b00, 4'd4});
      else passed++;
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  sz;
    logic [1:0]  bu;
    logic [3:0]  id;
    logic [1:0]  eb;
    int nb, pick;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        wd[i] = $urandom; ws[i] = 4'hF;
      end
      do_write(32'h8000_0000 + 32'(k * 1024), 0, 255, 2, 1, 256, 0);
    end
    for (int t = 0; t < 40; t++) begin
      pick = $urandom_range(0, 9);
      len = 8'($urandom_range(0, 7));
      sz = 3'd2;
      bu = 2'($urandom_range(0, 1));
      if (pick < 6) a = 32'h8000_0000 + 32'($urandom_range(0, 1023) * 4);
      else if (pick < 8) begin
        a = 32'h8000_0FF0 + 32'($urandom_range(0, 3) * 4);
        bu = 2'b01; len = 8'd7;
      end else if (pick == 8) begin
        a = 32'h8000_0200; bu = 2'b10;
      end else begin
        a = 32'h8000_0300; sz = 3'($urandom_range(0, 1));
      end
      nb = int'(len) + 1;
      if ($urandom_range(0, 4) == 0) nb = $urandom_range(1, int'(len) + 2);
      id = 4'($urandom);
      for (int i = 0; i < nb; i++) begin
        wd[i] = $urandom; ws[i] = 4'($urandom);
      end
      eb = (nb == int'(len) + 1) ? 2'b00 : 2'b10;
      for (int i = 0; i < nb; i++)
        if (!ref_ok(beat_addr(a, bu, sz, i), bu, sz)) eb = 2'b10;
      do_write(a, id, len, sz, bu, nb, $urandom_range(0, 2));
      total++;
      if ({b_resp, b_id} !== {eb, id})
        $display("FAIL rnd%0d_b got %h want %h", t, {b_resp, b_id},
                 {eb, id});
      else passed++;
      do_read(a, id, len, sz, bu, 2);
      total++;
      if (rd_n !== int'(len) + 1)
        $display("FAIL rnd%0d_n got %0d want %0d", t, rd_n, len + 1);
      else passed++;
      for (int i = 0; i <= int'(len) && i < rd_n; i++) begin
        total++;
        if ({rd_data[i], rd_resp[i], rd_last[i], rd_id[i]} !==
            {exp_data(a, bu, sz, i),
             ref_ok(beat_addr(a, bu, sz, i), bu, sz) ? 2'b00 : 2'b10,
             i == int'(len), id})
          $display("FAIL rnd%0d_beat%0d got %h want %h", t, i,
                   {rd_data[i], rd_resp[i], rd_last[i], rd_id[i]},
                   {exp_data(a, bu, sz, i),
                    ref_ok(beat_addr(a, bu, sz, i), bu, sz) ?
                    2'b00 : 2'b10, i == int'(len), id});
        else passed++;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_arbitration;
    test_single;
    test_incr_read;
    test_strobe;
    test_error;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
